// File: rtl/tdc_pkg.sv
// Shared TDC definitions: controller state encoding and default code widths.
// Used by the measurement controller, the tap encoder and the host interface.
package tdc_pkg;

    localparam int COARSE_W_DEF = 16;
    localparam int FINE_W_DEF   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } tdc_state_t;

endpackage

// File: rtl/tdc_meas_ctrl_if.sv
// Host/datapath bundle of the TDC measurement controller; master = host and sampler side,
// slave = controller. Result leaves on a valid/ready pair, events are single-cycle pulses.
interface tdc_meas_ctrl_if
    import tdc_pkg::*;
#(
    parameter int COARSE_W = COARSE_W_DEF,
    parameter int FINE_W   = FINE_W_DEF
);
    logic                arm;
    logic                self_test;
    logic                pulse_out;
    logic                start_evt;
    logic [FINE_W-1:0]   start_fine;
    logic                stop_evt;
    logic [FINE_W-1:0]   stop_fine;
    logic                busy;
    logic                res_valid;
    logic                res_ready;
    logic [COARSE_W-1:0] res_coarse;
    logic [FINE_W-1:0]   res_fine_start;
    logic [FINE_W-1:0]   res_fine_stop;
    logic                res_timeout;

    modport master (
        output arm, self_test, start_evt, start_fine, stop_evt, stop_fine, res_ready,
        input  pulse_out, busy, res_valid, res_coarse, res_fine_start, res_fine_stop, res_timeout
    );

    modport slave (
        input  arm, self_test, start_evt, start_fine, stop_evt, stop_fine, res_ready,
        output pulse_out, busy, res_valid, res_coarse, res_fine_start, res_fine_stop, res_timeout
    );

endinterface

// File: rtl/tdc_sat_counter.sv
// Clearable up-counter that sticks at all-ones; one cycle from clr/en to cnt.
// No backpressure: clr has priority over en.
module tdc_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !(&cnt)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Sequences one TDC measurement: arm, optional self-test pulse, coarse count start->stop, timeout.
// res_valid rises the cycle after stop (or after TIMEOUT armed/run cycles) and holds until res_ready.
module tdc_meas_ctrl
    import tdc_pkg::*;
#(
    parameter int COARSE_W  = COARSE_W_DEF,
    parameter int FINE_W    = FINE_W_DEF,
    parameter int TIMEOUT   = 4096,
    parameter int PULSE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    tdc_meas_ctrl_if.slave   bus
);

    localparam int                  PW        = (PULSE_CYC < 2) ? 1 : $clog2(PULSE_CYC);
    localparam logic [COARSE_W-1:0] TMO_LAST  = COARSE_W'(TIMEOUT - 1);
    localparam logic [PW-1:0]       PLS_LAST  = PW'(PULSE_CYC - 1);

    tdc_state_t state, state_nxt;

    logic [COARSE_W-1:0] coarse_cnt, tmo_cnt, coarse_inc;
    logic [PW-1:0]       pulse_cnt;
    logic                arm_acc, active, tmo_hit, pulse_last;
    logic                done_norm, done_tmo, cap_start;

    logic                busy_q, valid_q, pulse_q, to_q;
    logic                busy_d, valid_d, pulse_d, to_d;
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [FINE_W-1:0]   fs_q, fs_d, fp_q, fp_d;

    assign arm_acc    = (state == ST_IDLE) && bus.arm;
    assign active     = (state == ST_ARMED) || (state == ST_RUN);
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign pulse_last = (pulse_cnt == PLS_LAST);
    assign coarse_inc = (&coarse_cnt) ? coarse_cnt : coarse_cnt + COARSE_W'(1);

    // A stop in the timeout cycle still counts as a real measurement.
    assign done_norm = ((state == ST_ARMED) && bus.start_evt && bus.stop_evt) ||
                       ((state == ST_RUN) && bus.stop_evt);
    assign done_tmo  = active && tmo_hit && !done_norm;
    assign cap_start = (state == ST_ARMED) && bus.start_evt && (bus.stop_evt || !tmo_hit);

    tdc_sat_counter #(.W(COARSE_W)) u_coarse_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (arm_acc || cap_start),
        .en    (state == ST_RUN),
        .cnt   (coarse_cnt)
    );

    tdc_sat_counter #(.W(COARSE_W)) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (arm_acc),
        .en    (active),
        .cnt   (tmo_cnt)
    );

    tdc_sat_counter #(.W(PW)) u_pulse_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (arm_acc),
        .en    (pulse_q),
        .cnt   (pulse_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (bus.arm) state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (done_norm || done_tmo) begin
                    state_nxt = ST_DONE;
                end else if (bus.start_evt) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:   if (done_norm || done_tmo) state_nxt = ST_DONE;
            ST_DONE:  if (bus.res_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; decoded from the next state so the flops line up.
    always_comb begin
        busy_d   = (state_nxt != ST_IDLE);
        valid_d  = (state_nxt == ST_DONE);
        pulse_d  = 1'b0;
        coarse_d = coarse_q;
        to_d     = to_q;
        fs_d     = fs_q;
        fp_d     = fp_q;
        if (arm_acc) begin
            pulse_d = bus.self_test;
        end else if ((state_nxt == ST_ARMED) || (state_nxt == ST_RUN)) begin
            pulse_d = pulse_q && !pulse_last;
        end
        if (done_tmo) begin
            coarse_d = '1;
            to_d     = 1'b1;
        end else if (done_norm) begin
            coarse_d = (state == ST_RUN) ? coarse_inc : '0;
            to_d     = 1'b0;
            fp_d     = bus.stop_fine;
        end
        if (cap_start) begin
            fs_d = bus.start_fine;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
            to_q     <= 1'b0;
            coarse_q <= '0;
            fs_q     <= '0;
            fp_q     <= '0;
        end else begin
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            pulse_q  <= pulse_d;
            to_q     <= to_d;
            coarse_q <= coarse_d;
            fs_q     <= fs_d;
            fp_q     <= fp_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.res_valid      = valid_q;
    assign bus.pulse_out      = pulse_q;
    assign bus.res_timeout    = to_q;
    assign bus.res_coarse     = coarse_q;
    assign bus.res_fine_start = fs_q;
    assign bus.res_fine_stop  = fp_q;

endmodule
